// File: rtl/uart_tx_sched.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte requesters,
// holding newd/dintx until the frame completes and aborting stuck frames with a watchdog.
`timescale 1ns/1ps
module uart_tx_sched #(
    parameter int NREQ      = 4,
    parameter int TO_CYCLES = 4096,
    parameter int TOW       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    newd,
    output logic [7:0]              dintx,
    input  logic                    donetx
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n, sel, after_grant, grant_n;
    logic [TOW-1:0]  wd, wd_n;
    logic            donetx_q, rise, expired, found;
    logic [NREQ-1:0] ack_n, done_n;
    logic            err_n, busy_n, newd_n;
    logic [7:0]      dintx_n;

    assign rise        = donetx & ~donetx_q;
    assign expired     = (wd >= TOW'(TO_CYCLES - 1));
    assign after_grant = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

    // Rotating priority search: the first requester at or after ptr wins.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_n = state;
        ptr_n   = ptr;
        wd_n    = wd;
        ack_n   = '0;
        done_n  = '0;
        err_n   = 1'b0;
        busy_n  = busy;
        grant_n = grant_id;
        newd_n  = newd;
        dintx_n = dintx;
        unique case (state)
            IDLE: begin
                // A high donetx here is left over from the previous frame; wait it out.
                if (found && !donetx) begin
                    state_n    = SEND;
                    grant_n    = sel;
                    dintx_n    = req_data[{sel, 3'b000} +: 8];
                    ack_n[sel] = 1'b1;
                    newd_n     = 1'b1;
                    busy_n     = 1'b1;
                    wd_n       = '0;
                end
            end
            SEND: begin
                if (rise) begin
                    newd_n  = 1'b0;
                    state_n = DRAIN;
                    wd_n    = wd + TOW'(1);
                end else if (expired) begin
                    err_n   = 1'b1;
                    newd_n  = 1'b0;
                    busy_n  = 1'b0;
                    ptr_n   = after_grant;
                    state_n = IDLE;
                end else begin
                    wd_n = wd + TOW'(1);
                end
            end
            DRAIN: begin
                if (!donetx) begin
                    done_n[grant_id] = 1'b1;
                    ptr_n            = after_grant;
                    busy_n           = 1'b0;
                    state_n          = IDLE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    newd_n  = 1'b0;
                    busy_n  = 1'b0;
                    ptr_n   = after_grant;
                    state_n = IDLE;
                end else begin
                    wd_n = wd + TOW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            wd       <= '0;
            donetx_q <= 1'b0;
            ack      <= '0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            newd     <= 1'b0;
            dintx    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            wd       <= wd_n;
            donetx_q <= donetx;
            ack      <= ack_n;
            done     <= done_n;
            err      <= err_n;
            busy     <= busy_n;
            grant_id <= grant_n;
            newd     <= newd_n;
            dintx    <= dintx_n;
        end
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter between NREQ byte requesters.
- Sits between client logic and the transmitter's newd/dintx/donetx interface.
- Grants one requester at a time and holds newd/dintx stable until the transmitter completes the frame.
- Reports per-requester accept and completion, and aborts stuck transfers with a watchdog timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TO_CYCLES, 4096, watchdog limit in clk cycles from grant to completion; must exceed one full frame plus one uclk period.
- TOW, 16, watchdog counter width; TO_CYCLES must be < 2**TOW.

Ports:
- clk  in  1  system clock; the transmitter's uclk is derived from it.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req  in  NREQ  level request per requester; sampled only in IDLE.
- req_data  in  NREQ*8  byte per requester; requester i uses bits [8i+7:8i].
- ack  out  NREQ  one-hot, 1-cycle pulse when requester i's byte is latched.
- done  out  NREQ  one-hot, 1-cycle pulse when requester i's frame is complete.
- err  out  1  1-cycle pulse on watchdog abort.
- busy  out  1  high in SEND and DRAIN.
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester.
- newd  out  1  to transmitter: new-data request.
- dintx  out  8  to transmitter: byte to send.
- donetx  in  1  from transmitter: done level, held high for one uclk period.

Behaviour:
- One clock (clk); reset is asynchronous and active-low.
- Reset values: ack=0, done=0, err=0, busy=0, newd=0, dintx=0, grant_id=0, rr pointer=0, watchdog=0, donetx_q=0, state=IDLE.
- Assertion of rst mid-transfer aborts immediately with no done/err pulse. The transmitter has its own reset.
- All outputs are registered.
- donetx_q is a 1-cycle delayed copy of donetx. rise = donetx & ~donetx_q.
- IDLE:
  - If |req and donetx==0, select the first i with req[i]=1, searching ptr, ptr+1, … mod NREQ.
  - Next cycle: dintx=req_data[i], grant_id=i, ack[i]=1, newd=1, busy=1, watchdog=0, state=SEND.
  - If donetx==1 (stale done from a previous frame), do not grant; wait.
  - req=0 means stay in IDLE.
- SEND:
  - newd and dintx are held constant; watchdog increments each cycle.
  - On rise: newd<=0, state=DRAIN.
  - A donetx that is already high on entry is not an edge and is ignored.
- DRAIN:
  - Wait for donetx==0.
  - Then done[grant_id]=1 for 1 cycle, ptr<=(grant_id+1) mod NREQ, busy<=0, state=IDLE.
- Watchdog (SEND or DRAIN): when the counter reaches TO_CYCLES-1:
  - err=1 for 1 cycle, newd<=0, busy<=0, ptr<=grant_id+1 mod NREQ, state=IDLE, no done pulse.
- Back-to-back: there is at least one IDLE cycle between done and the next ack.
- Fairness: after requester i is served, i has the lowest priority. Worst-case wait is NREQ-1 frames.
- Requester handshake: a requester may change req/req_data any time after its ack. A req dropped before grant is simply not served.
- Simultaneous events:
  - rise and watchdog expiry in the same cycle: rise wins (go to DRAIN, counter keeps running).
  - donetx falling and expiry in the same DRAIN cycle: done wins.
- Pointer wrap: grant_id=NREQ-1 gives ptr=0.

Test Plan:
- NREQ=4, req=4'b0100, req_data[23:16]=8'hA5, transmitter model pulses donetx for 52 clks after 1000 clks -> ack=4'b0100 one cycle after request, dintx=8'hA5, newd high until donetx rise, done=4'b0100 one cycle after donetx falls, busy low afterwards.
- req=4'b1111 held, bytes 8'h11/22/33/44 -> grant order 0,1,2,3,0; each ack follows the previous done by >=1 cycle; newd never overlaps donetx low-to-high twice per grant.
- donetx held high at reset release, req=4'b0001 -> no ack until donetx==0, then grant 0; the stale high level must not produce done.
- donetx stuck low, TO_CYCLES=100 -> err pulses 100 cycles after ack, newd=0, no done, next request (ptr=1) served normally.
- rst driven low 5 cycles into SEND for requester 2 -> newd, busy, grant_id, ack, done all 0 asynchronously; after release, req=4'b0100 is granted again from ptr=0.
- Served requester 3, then req=4'b1001 -> grant 0 (pointer wrap), then 3.
